// File: rtl/debug_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : debug_btn_conditioner
// Purpose  : Conditions raw FPGA debug buttons/switches on the clk_7seg
//            domain. Each input is synchronised with two flops, debounced by a
//            four-state FSM, and reported as a stable level plus one-cycle
//            press/release pulses. The UP/DN buttons step a display-page index
//            that the top level uses to pick the word shown on the 7-seg.
// Ports    : clk_7seg     in   1       scan clock, the only clock
//            Rst          in   1       synchronous, active-high reset
//            btn_raw      in   N_BTN   asynchronous raw buttons/switches
//            btn_level    out  N_BTN   debounced level
//            btn_press    out  N_BTN   1-cycle pulse on accepted 0->1
//            btn_release  out  N_BTN   1-cycle pulse on accepted 1->0
//            page         out  PAGE_W  display page index
//            page_step    out  1       1-cycle pulse whenever page changes
// Options  : define AUTOREPEAT_EN to make a held UP/DN button auto-repeat
//            page steps after RPT_DELAY cycles, then every RPT_RATE cycles.
//            Without it no repeat logic exists and RPT_* are only
//            range-checked.
// Revision : 1.0  initial release
// ============================================================================
module debug_btn_conditioner #(
  parameter int N_BTN     = 5,
  parameter int DB_CYCLES = 250,
  parameter int UP_IDX    = 0,
  parameter int DN_IDX    = 1,
  parameter int PAGE_W    = 3,
  parameter int RPT_DELAY = 12500,
  parameter int RPT_RATE  = 2500
) (
  input  logic              clk_7seg,
  input  logic              Rst,
  input  logic [N_BTN-1:0]  btn_raw,
  output logic [N_BTN-1:0]  btn_level,
  output logic [N_BTN-1:0]  btn_press,
  output logic [N_BTN-1:0]  btn_release,
  output logic [PAGE_W-1:0] page,
  output logic              page_step
);

  localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Elaboration-time guard against configurations the FSM cannot honour.
  if (DB_CYCLES < 2 || UP_IDX == DN_IDX || UP_IDX >= N_BTN || DN_IDX >= N_BTN ||
      UP_IDX < 0 || DN_IDX < 0 || PAGE_W < 1 || RPT_RATE < 1 ||
      RPT_RATE > RPT_DELAY) begin : g_bad_param
    $error("debug_btn_conditioner: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // level 0, stable
    ST_PWAIT = 2'd1,  // level 0, qualifying a press
    ST_HELD  = 2'd2,  // level 1, stable
    ST_RWAIT = 2'd3   // level 1, qualifying a release
  } db_state_e;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser; sync2_q is the only view of btn_raw used below.
  // --------------------------------------------------------------------------
  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;

  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Next-cycle values of the registered outputs, gathered from each bit.
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] press_d;
  logic [N_BTN-1:0] release_d;

`ifdef AUTOREPEAT_EN
  // [0] = UP button sitting in HELD, [1] = DN button sitting in HELD
  logic [1:0] rpt_held;
`endif

  // --------------------------------------------------------------------------
  // Per-bit debounce FSM
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_BTN; i++) begin : g_bit
    db_state_e        state_q;
    db_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_bit_d;
    logic             release_bit_d;

    always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      press_bit_d   = 1'b0;
      release_bit_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sync2_q[i]) begin
            state_d = ST_PWAIT;
            cnt_d   = CNT_ONE;
          end
        end
        ST_PWAIT: begin
          if (!sync2_q[i]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q >= CNT_LAST) begin
            // >= rather than == keeps the counter from ever wrapping
            state_d     = ST_HELD;
            cnt_d       = '0;
            press_bit_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_HELD: begin
          if (!sync2_q[i]) begin
            state_d = ST_RWAIT;
            cnt_d   = CNT_ONE;
          end
        end
        ST_RWAIT: begin
          if (sync2_q[i]) begin
            // glitch shorter than the debounce window: stay pressed
            state_d = ST_HELD;
            cnt_d   = '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_d       = ST_IDLE;
            cnt_d         = '0;
            release_bit_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk_7seg) begin
      if (Rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign level_d[i]   = (state_d == ST_HELD) || (state_d == ST_RWAIT);
    assign press_d[i]   = press_bit_d;
    assign release_d[i] = release_bit_d;

`ifdef AUTOREPEAT_EN
    if (i == UP_IDX) begin : g_up_held
      assign rpt_held[0] = (state_q == ST_HELD);
    end
    if (i == DN_IDX) begin : g_dn_held
      assign rpt_held[1] = (state_q == ST_HELD);
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Step sources for the page index
  // --------------------------------------------------------------------------
  logic step_up;
  logic step_dn;

`ifdef AUTOREPEAT_EN
  localparam int               RPT_W      = $clog2(RPT_DELAY + 1);
  localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(RPT_DELAY - 1);
  // After a repeat the counter restarts part-way so the next fire lands
  // RPT_RATE cycles later while sharing the single fire comparator.
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(RPT_DELAY - RPT_RATE);

  logic [1:0] rpt_step;

  for (genvar k = 0; k < 2; k++) begin : g_rpt
    logic [RPT_W-1:0] rpt_cnt_q;
    logic [RPT_W-1:0] rpt_cnt_d;
    logic             fire;

    always_comb begin
      rpt_cnt_d = '0;
      fire      = 1'b0;
      if (rpt_held[k]) begin
        if (rpt_cnt_q == RPT_FIRE) begin
          fire      = 1'b1;
          rpt_cnt_d = RPT_RELOAD;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_7seg) begin
      if (Rst) begin
        rpt_cnt_q <= '0;
      end else begin
        rpt_cnt_q <= rpt_cnt_d;
      end
    end

    assign rpt_step[k] = fire;
  end

  assign step_up = press_d[UP_IDX] | rpt_step[0];
  assign step_dn = press_d[DN_IDX] | rpt_step[1];
`else
  assign step_up = press_d[UP_IDX];
  assign step_dn = press_d[DN_IDX];
`endif

  // --------------------------------------------------------------------------
  // Page index: driven from the next-cycle press so page, page_step and
  // btn_press all change on the same edge. Opposing steps cancel.
  // --------------------------------------------------------------------------
  logic [PAGE_W-1:0] page_q;
  logic [PAGE_W-1:0] page_d;
  logic              page_step_q;
  logic              page_step_d;

  always_comb begin
    page_d      = page_q;
    page_step_d = 1'b0;
    if (step_up && !step_dn) begin
      page_d      = page_q + 1'b1;
      page_step_d = 1'b1;
    end else if (step_dn && !step_up) begin
      page_d      = page_q - 1'b1;
      page_step_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;

  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      page_q      <= '0;
      page_step_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      page_q      <= page_d;
      page_step_q <= page_step_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign page        = page_q;
  assign page_step   = page_step_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_btn_conditioner
// Purpose  : Self-checking bench for debug_btn_conditioner (default params).
//            A behavioural model (run-length debounce, modular page arithmetic,
//            hold-age repeat rule) is compared against the DUT every cycle;
//            a vector table and hand-written sequences add directed checks.
//            Define AUTOREPEAT_EN for both DUT and bench to test repeats.
// Revision : 1.0  initial release
// ============================================================================
module tb_debug_btn_conditioner;

  localparam int N     = 5;
  localparam int DB    = 250;
  localparam int UP    = 0;
  localparam int DN    = 1;
  localparam int PW    = 3;
  localparam int PAGES = 1 << PW;
`ifdef AUTOREPEAT_EN
  localparam int RDLY  = 12500;
  localparam int RRATE = 2500;
`endif

  logic          clk_7seg = 1'b0;
  logic          Rst      = 1'b1;
  logic [N-1:0]  btn_raw  = '0;
  logic [N-1:0]  btn_level;
  logic [N-1:0]  btn_press;
  logic [N-1:0]  btn_release;
  logic [PW-1:0] page;
  logic          page_step;

  int n_pass  = 0;
  int n_total = 0;

  debug_btn_conditioner dut (
    .clk_7seg    (clk_7seg),
    .Rst         (Rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .page        (page),
    .page_step   (page_step)
  );

  always #5 clk_7seg = ~clk_7seg;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Behavioural reference model
  // --------------------------------------------------------------------------
  logic [N-1:0] raw_hist[$];     // raw values not yet visible past the sync
  logic [N-1:0] m_level;
  int           m_run[N];        // consecutive samples disagreeing with level
  int           m_age[2];        // edges spent stably held (UP, DN)
  logic [N-1:0] m_press;
  logic [N-1:0] m_release;
  int           m_page;
  logic         m_step;

  function automatic void model_edge(input logic [N-1:0] raw, input logic rst);
    logic [N-1:0] s;
    logic [1:0]   rep;
    logic         up;
    logic         dn;
    rep = 2'b00;
    if (rst) begin
      raw_hist.delete();
      raw_hist.push_back('0);
      raw_hist.push_back('0);
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
      m_page    = 0;
      m_step    = 1'b0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_age[0] = 0;
      m_age[1] = 0;
      return;
    end
    raw_hist.push_back(raw);
    s = raw_hist.pop_front();
    m_press   = '0;
    m_release = '0;
`ifdef AUTOREPEAT_EN
    for (int k = 0; k < 2; k++) begin
      int idx;
      idx = (k == 0) ? UP : DN;
      if (m_level[idx] && m_run[idx] == 0) m_age[k]++;
      else m_age[k] = 0;
      rep[k] = (m_age[k] >= RDLY) && (((m_age[k] - RDLY) % RRATE) == 0);
    end
`endif
    for (int i = 0; i < N; i++) begin
      if (s[i] != m_level[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == DB) begin
        m_level[i] = ~m_level[i];
        if (m_level[i]) m_press[i] = 1'b1;
        else m_release[i] = 1'b1;
        m_run[i] = 0;
      end
    end
    up = m_press[UP] | rep[0];
    dn = m_press[DN] | rep[1];
    m_step = up ^ dn;
    if (up && !dn) m_page = (m_page + 1) % PAGES;
    else if (dn && !up) m_page = (m_page + PAGES - 1) % PAGES;
  endfunction

  function automatic void check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endfunction

  // One clock: drive, advance model on the edge, compare 1 time unit later.
  task automatic cyc(input logic [N-1:0] raw, input logic rst);
    logic [3*N+PW:0] act;
    logic [3*N+PW:0] exp;
    btn_raw = raw;
    Rst     = rst;
    @(posedge clk_7seg);
    model_edge(raw, rst);
    #1;
    act = {btn_level, btn_press, btn_release, page, page_step};
    exp = {m_level, m_press, m_release, PW'(m_page), m_step};
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL model @%0t: got lvl/prs/rel/page/step=%h/%h/%h/%0d/%b expected %h/%h/%h/%0d/%b",
                  $time, btn_level, btn_press, btn_release, page, page_step,
                  m_level, m_press, m_release, m_page, m_step);
  endtask

  // --------------------------------------------------------------------------
  // Vector table: {raw, hold cycles, level, page, steps seen, presses seen}
  // --------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0] raw;
    int           cycles;
    logic [N-1:0] exp_level;
    int           exp_page;
    int           exp_steps;
    logic [N-1:0] exp_por;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int           first_t;
    int           extra;
    int           steps;
    logic [N-1:0] por;
    logic [N-1:0] raw;
    int           step_t[$];
    int           exp_t[$];
    int           hold[N];
    logic [N-1:0] rnd_val;

    tbl[0]  = '{5'h00,  10, 5'h00, 0, 0, 5'h00};
    tbl[1]  = '{5'h01, 300, 5'h01, 1, 1, 5'h01};
    tbl[2]  = '{5'h00, 300, 5'h00, 1, 0, 5'h00};
    tbl[3]  = '{5'h02, 300, 5'h02, 0, 1, 5'h02};
    tbl[4]  = '{5'h00, 300, 5'h00, 0, 0, 5'h00};
    tbl[5]  = '{5'h02, 300, 5'h02, 7, 1, 5'h02};  // 0 -> 7 wrap
    tbl[6]  = '{5'h00, 300, 5'h00, 7, 0, 5'h00};
    tbl[7]  = '{5'h01, 300, 5'h01, 0, 1, 5'h01};  // 7 -> 0 wrap
    tbl[8]  = '{5'h1C, 300, 5'h1C, 0, 0, 5'h1C};
    tbl[9]  = '{5'h03, 300, 5'h03, 0, 0, 5'h03};  // UP+DN together cancel
    tbl[10] = '{5'h00, 300, 5'h00, 0, 0, 5'h00};
    tbl[11] = '{5'h1F, 100, 5'h00, 0, 0, 5'h00};  // too short to accept
    tbl[12] = '{5'h00, 300, 5'h00, 0, 0, 5'h00};

    // ---- reset with all inputs high, then hold after release -------------
    cyc(5'h1F, 1'b1);
    cyc(5'h1F, 1'b1);
    check("reset_outputs", int'({btn_level, btn_press, btn_release, page, page_step}), 0);
    first_t = -1; extra = 0;
    for (int t = 1; t <= 260; t++) begin
      cyc(5'h1F, 1'b0);
      if (btn_press == 5'h1F && first_t < 0) first_t = t;
      else if (btn_press != 0) extra++;
    end
    check("reset_hold_press_cycle", first_t, 252);
    check("reset_hold_extra_press", extra, 0);
    check("reset_hold_page_unchanged", int'(page), 0);
    for (int t = 0; t < 260; t++) cyc(5'h00, 1'b0);
    check("reset_hold_released", int'(btn_level), 0);

    // ---- bounce on bit 2 ---------------------------------------------------
    first_t = -1; extra = 0;
    for (int t = 0; t < 1300; t++) begin
      raw = '0;
      raw[2] = (t >= 1000) || (((t / 40) % 2) == 0);
      cyc(raw, 1'b0);
      if (btn_press == 5'h04 && first_t < 0) first_t = t;
      else if (btn_press != 0 || btn_release != 0) extra++;
    end
    check("bounce_press_cycle", first_t, 960 + 251);
    check("bounce_spurious_pulses", extra, 0);
    for (int t = 0; t < 260; t++) cyc(5'h00, 1'b0);

    // ---- table-driven vectors ---------------------------------------------
    cyc(5'h00, 1'b1);
    cyc(5'h00, 1'b1);
    foreach (tbl[r]) begin
      steps = 0; por = '0;
      for (int t = 0; t < tbl[r].cycles; t++) begin
        cyc(tbl[r].raw, 1'b0);
        steps += int'(page_step);
        por   |= btn_press;
      end
      check($sformatf("tbl%0d_level", r),   int'(btn_level), int'(tbl[r].exp_level));
      check($sformatf("tbl%0d_page", r),    int'(page),      tbl[r].exp_page);
      check($sformatf("tbl%0d_steps", r),   steps,           tbl[r].exp_steps);
      check($sformatf("tbl%0d_presses", r), int'(por),       int'(tbl[r].exp_por));
    end

    // ---- reset in the middle of debouncing bit 0 --------------------------
    extra = 0;
    for (int t = 1; t <= 102; t++) begin
      cyc(5'h01, 1'b0);
      extra += int'(btn_press != 0);
    end
    cyc(5'h01, 1'b1);
    extra += int'(btn_press != 0);
    cyc(5'h01, 1'b1);
    extra += int'(btn_press != 0);
    check("midrst_outputs_cleared", int'({btn_level, page, page_step}), 0);
    first_t = -1;
    for (int t = 1; t <= 260; t++) begin
      cyc(5'h01, 1'b0);
      if (btn_press == 5'h01 && first_t < 0) first_t = t;
      else if (btn_press != 0) extra++;
    end
    check("midrst_press_cycle", first_t, 252);
    check("midrst_spurious_press", extra, 0);
    check("midrst_page_after", int'(page), 1);
    for (int t = 0; t < 260; t++) cyc(5'h00, 1'b0);

    // ---- long hold of UP from page 0 --------------------------------------
    cyc(5'h00, 1'b1);
    cyc(5'h00, 1'b1);
    for (int t = 1; t <= 20000; t++) begin
      cyc(5'h01, 1'b0);
      if (page_step) step_t.push_back(t);
    end
`ifdef AUTOREPEAT_EN
    exp_t = '{252, 252 + 12500, 252 + 15000, 252 + 17500};
    check("hold_page", int'(page), 4);
`else
    exp_t = '{252};
    check("hold_page", int'(page), 1);
`endif
    check("hold_step_count", step_t.size(), exp_t.size());
    for (int i = 0; i < exp_t.size() && i < step_t.size(); i++)
      check($sformatf("hold_step%0d_cycle", i), step_t[i], exp_t[i]);
    for (int t = 0; t < 260; t++) cyc(5'h00, 1'b0);

    // ---- randomized stimulus against the model ----------------------------
    cyc(5'h00, 1'b1);
    rnd_val = '0;
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 600);
    for (int t = 0; t < 6000; t++) begin
      for (int i = 0; i < N; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          rnd_val[i] = ~rnd_val[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60)
                                                  : $urandom_range(200, 700);
        end
      end
      cyc(rnd_val, ($urandom_range(0, 2999) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
